// File: rtl/pad_writer.sv
// pad_writer: fills the zero-padded N x N image BRAM (N = M + 2*PAD) used by
// the 3x3 convolution engine. Raw M x M pixels arrive row-major on a
// valid/ready stream; border positions are written as zero without stalling.
// Optional build macro SOF_CHECK_EN adds s_sof / err start-of-frame checking.
module pad_writer #(
   parameter int M   = 128,
   parameter int PAD = 1,
   parameter int AW  = 15,
   parameter int DW  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
`ifdef SOF_CHECK_EN
   input  logic          s_sof,
   output logic          err,
`endif
   output logic          s_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          busy,
   output logic          done
);

   localparam int N  = M + 2 * PAD;
   localparam int CW = (N > 2) ? $clog2(N) : 1;

   localparam logic [CW-1:0] C_LAST = CW'(N - 1);
   localparam logic [CW-1:0] C_LO   = CW'(PAD);
   localparam logic [CW-1:0] C_HI   = CW'(N - PAD);
   localparam logic [AW-1:0] A_LAST = AW'(N * N - 1);

   // The address space must hold every padded pixel.
   if ((64'd1 << AW) < 64'(N * N)) begin : g_aw_check
      $error("pad_writer: AW too small for N*N addresses");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   row;
   logic [CW-1:0]   col;
   logic [AW-1:0]   addr;

   logic            interior;
   logic            advance;
   logic [DW-1:0]   wr_data;

   // A position is border when it lies in the first/last PAD rows or columns.
   function automatic logic is_border(input logic [CW-1:0] r, input logic [CW-1:0] c);
      return (r < C_LO) || (r >= C_HI) || (c < C_LO) || (c >= C_HI);
   endfunction

   // Position classification, stream handshake and write data selection.
   always_comb begin
      interior = !is_border(row, col);
      s_ready  = (state == S_FILL) && interior;
      advance  = (state == S_FILL) && (!interior || s_valid);
      wr_data  = interior ? s_data : '0;
   end

`ifdef SOF_CHECK_EN
   logic first_pos;

   // The first interior pixel is the only one allowed to carry s_sof.
   always_comb begin
      first_pos = (row == C_LO) && (col == C_LO);
   end
`endif

   // Frame-fill state machine with registered BRAM port and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         row      <= '0;
         col      <= '0;
         addr     <= '0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef SOF_CHECK_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (start) begin
                  state <= S_FILL;
                  row   <= '0;
                  col   <= '0;
                  addr  <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
`ifdef SOF_CHECK_EN
                  err   <= 1'b0;
`endif
               end
            end

            S_FILL: begin
               if (advance) begin
                  mem_en   <= 1'b1;
                  mem_we   <= 1'b1;
                  mem_addr <= addr;
                  mem_din  <= wr_data;
                  addr     <= addr + 1'b1;
                  if (col == C_LAST) begin
                     col <= '0;
                     row <= row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
                  if (addr == A_LAST) begin
                     state <= S_FLUSH;
                  end
               end else begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
               end
`ifdef SOF_CHECK_EN
               if (s_valid && s_ready && (first_pos != s_sof)) begin
                  err <= 1'b1;
               end
`endif
            end

            S_FLUSH: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= S_DONE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
